t07_mmio_router: RTL and testbench

- Sequential, parametrised MMIO router between the CPU memory handler and N memory-mapped targets (instruction/data memory via wishbone manager, external register file, SPI TFT, spare).
- Replaces the combinational fixed-window decoder.
- Arbitrates between the instruction-fetch and data ports, decodes the address against per-channel base/limit windows, and runs a registered request/acknowledge handshake per transaction.
- Adds timeout and decode-error responses.

---
 rtl/t07_mmio_pkg.sv | 46 ++++
 rtl/t07_mmio_decode.sv | 41 ++++
 rtl/t07_mmio_router.sv | 175 +++++++++++++++++
 tb/tb_t07_mmio_router.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/t07_mmio_pkg.sv
// Shared types and default address map for the MMIO router.
package t07_mmio_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP,
        ST_ERR
    } state_t;

    typedef enum logic {
        PORT_FETCH,
        PORT_DATA
    } port_t;

    localparam int CH_REG  = 0;
    localparam int CH_DMEM = 1;
    localparam int CH_TFT  = 2;
    localparam int CH_IMEM = 3;

    localparam int DEF_NCH = 4;
    localparam int DEF_AW  = 32;

    localparam logic [7:0] DEF_TIMEOUT = 8'd255;

    // Width of a channel index; never zero, even for a single channel.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Default inclusive window per channel (sel = 0: base, sel = 1: limit).
    // Element 0 of the packed array is the leftmost entry, i.e. channel 0.
    function automatic logic [0:DEF_NCH-1][DEF_AW-1:0] default_window(input bit sel);
        logic [0:DEF_NCH-1][DEF_AW-1:0] w;
        w = '0;
        w[CH_REG]  = sel ? 32'd1056 : 32'd1025;
        w[CH_DMEM] = sel ? 32'd1792 : 32'd1057;
        w[CH_TFT]  = sel ? 32'd2047 : 32'd1793;
        w[CH_IMEM] = sel ? 32'd1024 : 32'd0;
        return w;
    endfunction

    localparam logic [0:DEF_NCH-1][DEF_AW-1:0] DEF_BASE  = default_window(1'b0);
    localparam logic [0:DEF_NCH-1][DEF_AW-1:0] DEF_LIMIT = default_window(1'b1);

endpackage

// File: rtl/t07_mmio_decode.sv
// Combinational address decoder: address -> {hit, channel index, one-hot}.
// Overlapping windows resolve to the lowest-index channel.
module t07_mmio_decode
    import t07_mmio_pkg::*;
#(
    parameter int AW  = 32,
    parameter int NCH = 4,
    parameter logic [0:NCH-1][AW-1:0] BASE  = '0,
    parameter logic [0:NCH-1][AW-1:0] LIMIT = '0,
    localparam int CW = idx_width(NCH)
) (
    input  logic [AW-1:0]  addr,
    output logic           hit,
    output logic [CW-1:0]  ch_idx,
    output logic [NCH-1:0] onehot
);

    logic [AW-1:0] lo;
    logic [AW-1:0] hi;

    // Scan from the highest channel down so the lowest matching one wins.
    always_comb begin
        // NOTE: every output gets a default before the loop so no latch is inferred.
        hit    = 1'b0;
        ch_idx = '0;
        onehot = '0;
        lo     = '0;
        hi     = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            lo = BASE[i];
            hi = LIMIT[i];
            if ((addr >= lo) && (addr <= hi)) begin
                hit       = 1'b1;
                ch_idx    = CW'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/t07_mmio_router.sv
// MMIO router: arbitrates fetch/data ports, decodes against per-channel
// windows and runs one registered request/ack transaction at a time, with
// decode-miss and timeout error responses.
module t07_mmio_router
    import t07_mmio_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int NCH = 4,
    parameter logic [0:NCH-1][AW-1:0] REGION_BASE  = DEF_BASE,
    parameter logic [0:NCH-1][AW-1:0] REGION_LIMIT = DEF_LIMIT,
    parameter logic [7:0] TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              fetch_req,
    input  logic [AW-1:0]     fetch_addr,
    output logic [DW-1:0]     fetch_instr,
    output logic              fetch_ready,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [AW-1:0]     data_addr,
    input  logic [DW-1:0]     data_wdata,
    output logic [DW-1:0]     data_rdata,
    output logic              data_ready,
    output logic              data_err,
    output logic              fetch_err,
    output logic [NCH-1:0]    tgt_req,
    output logic              tgt_we,
    output logic [AW-1:0]     tgt_addr,
    output logic [DW-1:0]     tgt_wdata,
    input  logic [NCH*DW-1:0] tgt_rdata,
    input  logic [NCH-1:0]    tgt_ack
);

    localparam int CW = idx_width(NCH);

    state_t          state;
    port_t           last_grant;   // also identifies the port of the live transaction
    logic [CW-1:0]   ch_q;
    logic [7:0]      cnt;
    logic [7:0]      cnt_nxt;

    logic            grant_fetch;
    logic [AW-1:0]   req_addr;
    logic            dec_hit;
    logic [CW-1:0]   dec_ch;
    logic [NCH-1:0]  dec_onehot;
    logic            ack_sel;
    logic [DW-1:0]   rdata_sel;

    // Round-robin pick between the two ports and mux the address to decode.
    always_comb begin
        grant_fetch = fetch_req && (!data_req || (last_grant == PORT_DATA));
        req_addr    = grant_fetch ? fetch_addr : data_addr;
    end

    t07_mmio_decode #(
        .AW    (AW),
        .NCH   (NCH),
        .BASE  (REGION_BASE),
        .LIMIT (REGION_LIMIT)
    ) u_decode (
        .addr   (req_addr),
        .hit    (dec_hit),
        .ch_idx (dec_ch),
        .onehot (dec_onehot)
    );

    // Select ack and read data of the latched channel; other channels are ignored.
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        cnt_nxt   = cnt + 8'd1;
        for (int i = 0; i < NCH; i++) begin
            if (ch_q == CW'(i)) begin
                ack_sel   = tgt_ack[i];
                rdata_sel = tgt_rdata[i*DW +: DW];
            end
        end
    end

    // Transaction FSM with registered target-side and response outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            // NOTE: the target-side datapath is reset as well so the bus reads all-zero after reset.
            state       <= ST_IDLE;
            last_grant  <= PORT_DATA;
            ch_q        <= '0;
            cnt         <= '0;
            tgt_req     <= '0;
            tgt_we      <= 1'b0;
            tgt_addr    <= '0;
            tgt_wdata   <= '0;
            fetch_ready <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_instr <= '0;
            data_ready  <= 1'b0;
            data_err    <= 1'b0;
            data_rdata  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout; the defaults below are
            // overridden by later assignments in the same cycle.
            fetch_ready <= 1'b0;
            fetch_err   <= 1'b0;
            fetch_instr <= '0;
            data_ready  <= 1'b0;
            data_err    <= 1'b0;
            data_rdata  <= '0;

            unique case (state)
                ST_IDLE: begin
                    if (fetch_req || data_req) begin
                        last_grant <= grant_fetch ? PORT_FETCH : PORT_DATA;
                        tgt_addr   <= req_addr;
                        tgt_we     <= grant_fetch ? 1'b0 : data_we;
                        tgt_wdata  <= grant_fetch ? '0 : data_wdata;
                        ch_q       <= dec_ch;
                        cnt        <= '0;
                        if (dec_hit) begin
                            tgt_req <= dec_onehot;
                            state   <= ST_ISSUE;
                        end else begin
                            state <= ST_ERR;
                            if (grant_fetch) begin
                                fetch_ready <= 1'b1;
                                fetch_err   <= 1'b1;
                            end else begin
                                data_ready <= 1'b1;
                                data_err   <= 1'b1;
                            end
                        end
                    end
                end

                ST_ISSUE: begin
                    if (ack_sel) begin
                        // An ack on the timeout cycle still counts as success.
                        tgt_req <= '0;
                        state   <= ST_RESP;
                        if (last_grant == PORT_FETCH) begin
                            fetch_ready <= 1'b1;
                            fetch_instr <= tgt_we ? '0 : rdata_sel;
                        end else begin
                            data_ready <= 1'b1;
                            data_rdata <= tgt_we ? '0 : rdata_sel;
                        end
                    end else if (cnt_nxt == TIMEOUT) begin
                        tgt_req <= '0;
                        state   <= ST_ERR;
                        if (last_grant == PORT_FETCH) begin
                            fetch_ready <= 1'b1;
                            fetch_err   <= 1'b1;
                        end else begin
                            data_ready <= 1'b1;
                            data_err   <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt_nxt;
                    end
                end

                ST_RESP, ST_ERR: begin
                    // Response pulse is on the outputs this cycle; hold off new
                    // grants so a still-held request is not served twice.
                    cnt   <= '0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_t07_mmio_router.sv
// Self-checking bench for t07_mmio_router: table-driven single transactions
// plus hand-written round-robin and mid-transaction reset sequences.
module tb_t07_mmio_router;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int NCH = 4;

    logic              clk = 1'b0;
    logic              nrst;
    logic              fetch_req;
    logic [AW-1:0]     fetch_addr;
    logic [DW-1:0]     fetch_instr;
    logic              fetch_ready;
    logic              data_req;
    logic              data_we;
    logic [AW-1:0]     data_addr;
    logic [DW-1:0]     data_wdata;
    logic [DW-1:0]     data_rdata;
    logic              data_ready;
    logic              data_err;
    logic              fetch_err;
    logic [NCH-1:0]    tgt_req;
    logic              tgt_we;
    logic [AW-1:0]     tgt_addr;
    logic [DW-1:0]     tgt_wdata;
    logic [NCH*DW-1:0] tgt_rdata;
    logic [NCH-1:0]    tgt_ack;

    int checks = 0;
    int errors = 0;

    t07_mmio_router dut (
        .clk         (clk),
        .nrst        (nrst),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_instr (fetch_instr),
        .fetch_ready (fetch_ready),
        .data_req    (data_req),
        .data_we     (data_we),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .data_ready  (data_ready),
        .data_err    (data_err),
        .fetch_err   (fetch_err),
        .tgt_req     (tgt_req),
        .tgt_we      (tgt_we),
        .tgt_addr    (tgt_addr),
        .tgt_wdata   (tgt_wdata),
        .tgt_rdata   (tgt_rdata),
        .tgt_ack     (tgt_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        bit           fetch;
        bit           we;
        logic [31:0]  addr;
        logic [31:0]  wdata;
        int           ack_dly;    // ack in the Nth cycle of tgt_req; 0 = never
        logic [31:0]  rdata;      // read data driven on the selected channel
        logic [3:0]   exp_req;
        bit           exp_err;
        logic [31:0]  exp_rdata;
        int           exp_lat;    // cycles from request sample to ready
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input string name, input bit fetch, input bit we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int ack_dly, input logic [31:0] rdata,
                           input logic [3:0] exp_req, input bit exp_err,
                           input logic [31:0] exp_rdata, input int exp_lat);
        vec_t v;
        v.name = name; v.fetch = fetch; v.we = we; v.addr = addr; v.wdata = wdata;
        v.ack_dly = ack_dly; v.rdata = rdata; v.exp_req = exp_req;
        v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_lat = exp_lat;
        vq.push_back(v);
    endtask

    task automatic idle_inputs();
        fetch_req  = 1'b0;
        fetch_addr = '0;
        data_req   = 1'b0;
        data_we    = 1'b0;
        data_addr  = '0;
        data_wdata = '0;
        tgt_ack    = '0;
        tgt_rdata  = '0;
    endtask

    task automatic reset_dut();
        nrst = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        nrst = 1'b1;
    endtask

    // One transaction: drive the request, act as the target, and compare the response.
    task automatic run_txn(input vec_t v);
        int cyc;
        int reqc;
        bit done;
        bit held_ok;
        bit stray;
        logic [3:0]  seen;
        logic [31:0] got_rd;
        logic        got_err;
        for (int i = 0; i < NCH; i++)
            tgt_rdata[i*DW +: DW] = v.exp_req[i] ? v.rdata : (32'hBAD0_0000 | 32'(i));
        @(negedge clk);
        if (v.fetch) begin
            fetch_req  = 1'b1;
            fetch_addr = v.addr;
        end else begin
            data_req   = 1'b1;
            data_we    = v.we;
            data_addr  = v.addr;
            data_wdata = v.wdata;
        end
        cyc = 0; reqc = 0; done = 1'b0; held_ok = 1'b1; stray = 1'b0;
        seen = '0; got_rd = '0; got_err = 1'b0;
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            tgt_ack = '0;
            if (v.fetch ? fetch_ready : data_ready) begin
                done    = 1'b1;
                got_rd  = v.fetch ? fetch_instr : data_rdata;
                got_err = v.fetch ? fetch_err : data_err;
            end
            if (v.fetch ? (data_ready | data_err) : (fetch_ready | fetch_err))
                stray = 1'b1;
            if (tgt_req != '0) begin
                reqc++;
                seen |= tgt_req;
                if (tgt_addr !== v.addr || tgt_we !== v.we || (v.we && tgt_wdata !== v.wdata))
                    held_ok = 1'b0;
                // Non-selected channels ack every cycle and must be ignored.
                tgt_ack = (reqc == v.ack_dly) ? v.exp_req : ~v.exp_req;
            end
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        data_we   = 1'b0;
        tgt_ack   = '0;
        check({v.name, " latency"},    cyc,      v.exp_lat);
        check({v.name, " err"},        got_err,  v.exp_err);
        check({v.name, " rdata"},      got_rd,   v.exp_rdata);
        check({v.name, " tgt_req"},    seen,     v.exp_req);
        check({v.name, " req_cycles"}, reqc,     (v.exp_req != '0) ? v.exp_lat - 1 : 0);
        check({v.name, " held"},       held_ok,  1);
        check({v.name, " other_port"}, stray,    0);
    endtask

    // Both ports held high back to back: grants must alternate, fetch first after reset.
    task automatic tie_seq();
        bit          exp_fetch [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [3:0]  exp_ch    [4] = '{4'b1000, 4'b0010, 4'b1000, 4'b0010};
        int          cyc;
        bit          done;
        bit          was_fetch;
        logic [3:0]  seen;
        logic [31:0] got_rd;
        for (int i = 0; i < NCH; i++) tgt_rdata[i*DW +: DW] = 32'hA000_0000 + 32'(i);
        @(negedge clk);
        fetch_req = 1'b1; fetch_addr = 32'd8;
        data_req  = 1'b1; data_addr  = 32'd1100; data_we = 1'b0;
        for (int n = 0; n < 4; n++) begin
            cyc = 0; done = 1'b0; was_fetch = 1'b0; seen = '0; got_rd = '0;
            while (!done && cyc < 20) begin
                @(negedge clk);
                cyc++;
                tgt_ack = '0;
                if (fetch_ready) begin
                    done = 1'b1; was_fetch = 1'b1; got_rd = fetch_instr;
                end else if (data_ready) begin
                    done = 1'b1; was_fetch = 1'b0; got_rd = data_rdata;
                end
                if (tgt_req != '0) begin
                    seen |= tgt_req;
                    tgt_ack = tgt_req;
                end
            end
            check($sformatf("tie%0d done", n),    done,      1);
            check($sformatf("tie%0d port", n),    was_fetch, exp_fetch[n]);
            check($sformatf("tie%0d channel", n), seen,      exp_ch[n]);
            check($sformatf("tie%0d rdata", n),   got_rd,    exp_fetch[n] ? 32'hA000_0003 : 32'hA000_0001);
        end
        fetch_req = 1'b0;
        data_req  = 1'b0;
        tgt_ack   = '0;
        @(negedge clk);
    endtask

    // Reset while a transaction is in ISSUE: no response, then a fresh request works.
    task automatic mid_reset_seq();
        bit stray;
        vec_t v;
        @(negedge clk);
        data_req = 1'b1; data_addr = 32'd1200; data_we = 1'b0;
        @(negedge clk);
        check("midrst tgt_req up", tgt_req, 4'b0010);
        @(negedge clk);
        nrst = 1'b0;
        data_req = 1'b0;
        @(negedge clk);
        check("midrst tgt_req dropped", tgt_req, 4'b0000);
        check("midrst tgt_addr", tgt_addr, 32'd0);
        check("midrst state idle", (dut.state == t07_mmio_pkg::ST_IDLE), 1);
        nrst = 1'b1;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (data_ready || fetch_ready || data_err || fetch_err || tgt_req != '0) stray = 1'b1;
        end
        check("midrst no response", stray, 0);
        v.name = "post_rst_rd"; v.fetch = 1'b0; v.we = 1'b0; v.addr = 32'd1100; v.wdata = '0;
        v.ack_dly = 2; v.rdata = 32'h0BAD_CAFE; v.exp_req = 4'b0010; v.exp_err = 1'b0;
        v.exp_rdata = 32'h0BAD_CAFE; v.exp_lat = 3;
        run_txn(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // name, fetch, we, addr, wdata, ack_dly, rdata, exp_req, exp_err, exp_rdata, exp_lat
        add_vec("rd_1040_ch0",   0, 0, 32'd1040, 32'h0,        1,   32'hDEADBEEF, 4'b0001, 0, 32'hDEADBEEF, 2);
        add_vec("wr_1900_ch2",   0, 1, 32'd1900, 32'h12345678, 5,   32'h55555555, 4'b0100, 0, 32'h0,        6);
        add_vec("rd_4096_miss",  0, 0, 32'd4096, 32'h0,        0,   32'h0,        4'b0000, 1, 32'h0,        1);
        add_vec("rd_1200_to",    0, 0, 32'd1200, 32'h0,        0,   32'h99999999, 4'b0010, 1, 32'h0,        256);
        add_vec("rd_1200_ackto", 0, 0, 32'd1200, 32'h0,        255, 32'hCAFEF00D, 4'b0010, 0, 32'hCAFEF00D, 256);
        add_vec("fetch_8_ch3",   1, 0, 32'd8,    32'h0,        2,   32'h00000013, 4'b1000, 0, 32'h00000013, 3);
        add_vec("rd_1056_ch0",   0, 0, 32'd1056, 32'h0,        1,   32'h11111111, 4'b0001, 0, 32'h11111111, 2);
        add_vec("rd_1057_ch1",   0, 0, 32'd1057, 32'h0,        1,   32'h22222222, 4'b0010, 0, 32'h22222222, 2);
        add_vec("rd_1024_ch3",   0, 0, 32'd1024, 32'h0,        3,   32'h33333333, 4'b1000, 0, 32'h33333333, 4);
        add_vec("rd_1025_ch0",   0, 0, 32'd1025, 32'h0,        1,   32'h44444444, 4'b0001, 0, 32'h44444444, 2);
        add_vec("rd_2047_ch2",   0, 0, 32'd2047, 32'h0,        1,   32'h66666666, 4'b0100, 0, 32'h66666666, 2);
        add_vec("rd_2048_miss",  0, 0, 32'd2048, 32'h0,        0,   32'h0,        4'b0000, 1, 32'h0,        1);
        add_vec("fetch_5000_miss", 1, 0, 32'd5000, 32'h0,      0,   32'h0,        4'b0000, 1, 32'h0,        1);
        add_vec("wr_0_ch3",      0, 1, 32'd0,    32'hA5A5A5A5, 1,   32'h77777777, 4'b1000, 0, 32'h0,        2);

        reset_dut();
        @(negedge clk);
        check("rst tgt_req",     tgt_req,     4'b0000);
        check("rst tgt_we",      tgt_we,      1'b0);
        check("rst tgt_addr",    tgt_addr,    32'd0);
        check("rst tgt_wdata",   tgt_wdata,   32'd0);
        check("rst fetch_ready", fetch_ready, 1'b0);
        check("rst data_ready",  data_ready,  1'b0);
        check("rst fetch_err",   fetch_err,   1'b0);
        check("rst data_err",    data_err,    1'b0);
        check("rst fetch_instr", fetch_instr, 32'd0);
        check("rst data_rdata",  data_rdata,  32'd0);

        tie_seq();

        for (int k = 0; k < vq.size(); k++) run_txn(vq[k]);

        mid_reset_seq();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
